// File: rtl/sort4_pkg.sv
// -----------------------------------------------------------------------------
// sort4_pkg
// Shared definitions for the 4-entry sorter frame sequencer:
//   - ctrl_state_e : sequencer state encoding
//   - SORT_SLOTS   : number of sorter slots (4)
//   - SLOT_W_MAX   : widest element the slot selector supports
//   - slot_sel()   : picks one element out of a packed sorter image
// -----------------------------------------------------------------------------
package sort4_pkg;

    localparam int unsigned SORT_SLOTS = 32'd4;

    // The slot selector works on a fixed-width image so it can live in the
    // package without a parameter; callers zero-extend their packed sorter
    // contents into this image and truncate the result to their own width.
    localparam int unsigned SLOT_W_MAX = 32'd64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_OUT   = 3'd3,
        ST_CLR   = 3'd4
    } ctrl_state_e;

    // Returns element 'slot' (slot 0 in the LSBs) of a packed image whose
    // elements are 'width' bits wide. Only the low 'width' result bits are
    // meaningful; the caller truncates.
    function automatic logic [SLOT_W_MAX-1:0] slot_sel(
        input logic [SORT_SLOTS*SLOT_W_MAX-1:0] q,
        input int unsigned                      width,
        input logic [1:0]                       slot
    );
        logic [SORT_SLOTS*SLOT_W_MAX-1:0] shifted;
        shifted = q >> (width * 32'(slot));
        return shifted[SLOT_W_MAX-1:0];
    endfunction

endpackage

// File: rtl/sort4_beat_counter.sv
// -----------------------------------------------------------------------------
// sort4_beat_counter
// Up-counter with synchronous clear and count enable. at_term is high while
// the count equals TERM, letting the owner act on the edge that would step
// past it.
//
// Parameters : WIDTH (counter width), TERM (terminal count value)
// Ports      : clk, rst (sync, active-high), clr (sync clear), en (count
//              enable), at_term (count == TERM)
// -----------------------------------------------------------------------------
module sort4_beat_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned TERM  = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_term
);

    logic [WIDTH-1:0] count_r;

    // Count register: reset and clear win over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            count_r <= {WIDTH{1'b0}};
        end else if (en) begin
            count_r <= count_r + WIDTH'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign at_term = (count_r == WIDTH'(TERM));

endmodule

// File: rtl/sort4_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sort4_frame_ctrl
// Frame sequencer for the 4-entry sequence sorter. Forwards FRAME_LEN
// accepted words into the sorter, waits SORT_LAT cycles for it to settle,
// streams the four sorted slots (largest first) downstream, then clears the
// sorter for the next frame.
//
// Parameters : DATA_WIDTH (<= 64), FRAME_LEN (1..65535), SORT_LAT (1..15)
// Ports      : clk, rst (sync, active-high)
//              in_valid/in_ready/in_data        upstream handshake
//              sorter_en/sorter_din/sorter_clr  sorter control
//              sorter_q                          sorter contents, slot 0 largest
//              out_valid/out_ready/out_data/out_last  sorted output handshake
//              frame_done                        one-cycle pulse at frame end
//              frame_min                         smallest word of the frame
// Build option: define SORT4_CTRL_MIN_EN to track frame_min; otherwise it
//              is tied to zero.
// -----------------------------------------------------------------------------
module sort4_frame_ctrl
    import sort4_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned SORT_LAT   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic                             sorter_en,
    output logic [DATA_WIDTH-1:0]            sorter_din,
    output logic                             sorter_clr,
    input  logic [SORT_SLOTS*DATA_WIDTH-1:0] sorter_q,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_last,
    output logic                             frame_done,
    output logic [DATA_WIDTH-1:0]            frame_min
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
    localparam int unsigned LAT_W = 4;

    ctrl_state_e state_r;
    ctrl_state_e state_next_s;
    logic [1:0]  idx_r;
    logic [1:0]  idx_next_s;

    logic        accept_s;
    logic        out_hs_s;
    logic        cnt_en_s;
    logic        cnt_clr_s;
    logic        cnt_last_s;
    logic        lat_en_s;
    logic        lat_clr_s;
    logic        lat_last_s;

    logic [SORT_SLOTS*SLOT_W_MAX-1:0] q_wide_s;

    // Handshake-facing decodes. rst gates them so nothing is offered or
    // accepted while reset is held, whatever state the register still shows.
    assign in_ready   = ~rst & ((state_r == ST_IDLE) | (state_r == ST_LOAD));
    assign accept_s   = in_valid & in_ready;
    assign sorter_en  = accept_s;
    assign sorter_din = in_data;
    assign sorter_clr = rst | (state_r == ST_CLR);
    assign out_valid  = ~rst & (state_r == ST_OUT);
    assign out_hs_s   = out_valid & out_ready;
    assign out_last   = out_valid & (idx_r == 2'd3);
    assign frame_done = ~rst & (state_r == ST_CLR);

    // Accepted-word counter: terminal one short of FRAME_LEN so the accept
    // that completes the frame is seen in the same cycle. cnt is zero in
    // IDLE, which also covers FRAME_LEN == 1.
    sort4_beat_counter #(
        .WIDTH (CNT_W),
        .TERM  (FRAME_LEN - 32'd1)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr_s),
        .en      (cnt_en_s),
        .at_term (cnt_last_s)
    );

    // Drain-cycle counter: at_term marks the last of SORT_LAT DRAIN cycles.
    sort4_beat_counter #(
        .WIDTH (LAT_W),
        .TERM  (SORT_LAT - 32'd1)
    ) u_lat (
        .clk     (clk),
        .rst     (rst),
        .clr     (lat_clr_s),
        .en      (lat_en_s),
        .at_term (lat_last_s)
    );

    // State and output-index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= 2'd0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
        end
    end

    // Next-state logic and counter controls.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        cnt_en_s     = 1'b0;
        cnt_clr_s    = 1'b0;
        lat_en_s     = 1'b0;
        lat_clr_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_LOAD: begin
                if (accept_s) begin
                    cnt_en_s = 1'b1;
                    if (cnt_last_s) begin
                        state_next_s = ST_DRAIN;
                        lat_clr_s    = 1'b1;
                    end else begin
                        state_next_s = ST_LOAD;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_DRAIN: begin
                lat_en_s = 1'b1;
                if (lat_last_s) begin
                    state_next_s = ST_OUT;
                    idx_next_s   = 2'd0;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_OUT: begin
                if (out_hs_s) begin
                    idx_next_s = idx_r + 2'd1;
                    if (idx_r == 2'd3) begin
                        state_next_s = ST_CLR;
                    end else begin
                        state_next_s = ST_OUT;
                    end
                end else begin
                    state_next_s = ST_OUT;
                end
            end
            ST_CLR: begin
                cnt_clr_s    = 1'b1;
                lat_clr_s    = 1'b1;
                idx_next_s   = 2'd0;
                state_next_s = ST_IDLE;
            end
            default: begin
                cnt_clr_s    = 1'b1;
                lat_clr_s    = 1'b1;
                idx_next_s   = 2'd0;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output word: slot idx of the settled sorter. The sorter is not enabled
    // outside IDLE/LOAD, so this stays stable while out_ready is low.
    always_comb begin
        q_wide_s = {(SORT_SLOTS*SLOT_W_MAX){1'b0}};
        q_wide_s[SORT_SLOTS*DATA_WIDTH-1:0] = sorter_q;
        if (state_r == ST_OUT) begin
            out_data = DATA_WIDTH'(slot_sel(q_wide_s, DATA_WIDTH, idx_r));
        end else begin
            out_data = {DATA_WIDTH{1'b0}};
        end
    end

`ifdef SORT4_CTRL_MIN_EN
    logic [DATA_WIDTH-1:0] frame_min_r;

    // Running minimum of accepted words; re-armed to all-ones between frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_min_r <= {DATA_WIDTH{1'b1}};
        end else if (state_r == ST_CLR) begin
            frame_min_r <= {DATA_WIDTH{1'b1}};
        end else if (accept_s && (in_data < frame_min_r)) begin
            frame_min_r <= in_data;
        end else begin
            frame_min_r <= frame_min_r;
        end
    end

    assign frame_min = frame_min_r;
`else
    assign frame_min = {DATA_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_sort4_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sort4_frame_ctrl
// Directed bench for sort4_frame_ctrl. Three controller instances with
// different frame lengths, each driving a behavioural top-4 sorter model.
//   u0 : FRAME_LEN=4,  SORT_LAT=1
//   u1 : FRAME_LEN=16, SORT_LAT=3
//   u2 : FRAME_LEN=2,  SORT_LAT=1
// Honours SORT4_CTRL_MIN_EN for the frame_min expectations.
// -----------------------------------------------------------------------------
module tb_sort4_frame_ctrl;

`ifdef SORT4_CTRL_MIN_EN
    localparam logic [7:0] MIN_IDLE = 8'hFF;
    localparam logic [7:0] MIN_T1   = 8'd1;
    localparam logic [7:0] MIN_T4   = 8'd5;
`else
    localparam logic [7:0] MIN_IDLE = 8'd0;
    localparam logic [7:0] MIN_T1   = 8'd0;
    localparam logic [7:0] MIN_T4   = 8'd0;
`endif

    logic        tb_clk;
    logic        rst;
    logic        in_valid   [3];
    logic        in_ready   [3];
    logic [7:0]  in_data    [3];
    logic        sorter_en  [3];
    logic [7:0]  sorter_din [3];
    logic        sorter_clr [3];
    logic [31:0] sq         [3];
    logic        out_valid  [3];
    logic        out_ready  [3];
    logic [7:0]  out_data   [3];
    logic        out_last   [3];
    logic        frame_done [3];
    logic [7:0]  frame_min  [3];

    int n_checks = 0;
    int n_pass   = 0;

    sort4_frame_ctrl #(.DATA_WIDTH(8), .FRAME_LEN(4), .SORT_LAT(1)) u0 (
        .clk(tb_clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .sorter_en(sorter_en[0]), .sorter_din(sorter_din[0]), .sorter_clr(sorter_clr[0]),
        .sorter_q(sq[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .frame_done(frame_done[0]), .frame_min(frame_min[0])
    );

    sort4_frame_ctrl #(.DATA_WIDTH(8), .FRAME_LEN(16), .SORT_LAT(3)) u1 (
        .clk(tb_clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .sorter_en(sorter_en[1]), .sorter_din(sorter_din[1]), .sorter_clr(sorter_clr[1]),
        .sorter_q(sq[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .frame_done(frame_done[1]), .frame_min(frame_min[1])
    );

    sort4_frame_ctrl #(.DATA_WIDTH(8), .FRAME_LEN(2), .SORT_LAT(1)) u2 (
        .clk(tb_clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .sorter_en(sorter_en[2]), .sorter_din(sorter_din[2]), .sorter_clr(sorter_clr[2]),
        .sorter_q(sq[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .out_last(out_last[2]), .frame_done(frame_done[2]), .frame_min(frame_min[2])
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // Keep the four largest words seen, slot 0 (LSBs) largest.
    function automatic logic [31:0] sort_ins(input logic [31:0] q, input logic [7:0] d);
        logic [7:0] s [5];
        logic [7:0] t;
        for (int i = 0; i < 4; i++) s[i] = q[i*8 +: 8];
        s[4] = d;
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 4; j++) begin
                if (s[j] < s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
            end
        end
        return {s[3], s[2], s[1], s[0]};
    endfunction

    // Behavioural sorters, one per controller.
    always @(posedge tb_clk) begin
        for (int u = 0; u < 3; u++) begin
            if (sorter_clr[u]) sq[u] <= 32'd0;
            else if (sorter_en[u]) sq[u] <= sort_ins(sq[u], sorter_din[u]);
        end
    end

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Offer one word; returns just after the edge that accepted it.
    task automatic send(input int u, input logic [7:0] d);
        int guard;
        guard = 0;
        in_valid[u] = 1'b1;
        in_data[u]  = d;
        while (!in_ready[u] && guard < 64) begin
            tick();
            guard++;
        end
        if (!in_ready[u]) chk("send_timeout", 32'(in_ready[u]), 32'd1);
        tick();
        in_valid[u] = 1'b0;
    endtask

    // Wait for an output beat and check it, then take it on the next edge.
    task automatic recv(input int u, input logic [7:0] d, input logic last, input string tag);
        int guard;
        guard = 0;
        while (!out_valid[u] && guard < 64) begin
            tick();
            guard++;
        end
        chk($sformatf("%s_valid", tag), 32'(out_valid[u]), 32'd1);
        chk($sformatf("%s_data", tag), 32'(out_data[u]), 32'(d));
        chk($sformatf("%s_last", tag), 32'(out_last[u]), 32'(last));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        logic seen, stable;

        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            in_valid[u] = 1'b0; in_data[u] = 8'd0; out_ready[u] = 1'b1;
        end
        in_valid[0] = 1'b1; in_data[0] = 8'hAA;
        tick(); tick();
        chk("rst_in_ready",   32'(in_ready[0]),   32'd0);
        chk("rst_sorter_en",  32'(sorter_en[0]),  32'd0);
        chk("rst_sorter_clr", 32'(sorter_clr[0]), 32'd1);
        chk("rst_out_valid",  32'(out_valid[0]),  32'd0);
        chk("rst_out_last",   32'(out_last[0]),   32'd0);
        chk("rst_frame_done", 32'(frame_done[0]), 32'd0);
        in_valid[0] = 1'b0;
        rst = 1'b0;
        #1;
        chk("idle_in_ready",   32'(in_ready[0]),   32'd1);
        chk("idle_sorter_clr", 32'(sorter_clr[0]), 32'd0);
        chk("idle_frame_min",  32'(frame_min[0]),  32'(MIN_IDLE));

        // Frame 3,9,1,7 back-to-back, FRAME_LEN=4, SORT_LAT=1.
        in_valid[0] = 1'b1; in_data[0] = 8'd3; #1;
        chk("t1_sorter_en",  32'(sorter_en[0]),  32'd1);
        chk("t1_sorter_din", 32'(sorter_din[0]), 32'd3);
        send(0, 8'd3); send(0, 8'd9); send(0, 8'd1); send(0, 8'd7);
        chk("t1_drain_valid", 32'(out_valid[0]), 32'd0);
        chk("t1_drain_ready", 32'(in_ready[0]),  32'd0);
        tick();
        chk("t1_first_valid", 32'(out_valid[0]), 32'd1);
        chk("t1_min_out",     32'(frame_min[0]), 32'(MIN_T1));
        recv(0, 8'd9, 1'b0, "t1_b0");
        recv(0, 8'd7, 1'b0, "t1_b1");
        recv(0, 8'd3, 1'b0, "t1_b2");
        recv(0, 8'd1, 1'b1, "t1_b3");
        chk("t1_clr_done",  32'(frame_done[0]), 32'd1);
        chk("t1_clr_sclr",  32'(sorter_clr[0]), 32'd1);
        chk("t1_clr_valid", 32'(out_valid[0]),  32'd0);
        tick();
        chk("t1_idle_done",  32'(frame_done[0]), 32'd0);
        chk("t1_idle_ready", 32'(in_ready[0]),   32'd1);
        chk("t1_idle_min",   32'(frame_min[0]),  32'(MIN_IDLE));

        // Frame 0..15 with a bubble between words, FRAME_LEN=16, SORT_LAT=3.
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick();
            send(1, 8'(i));
        end
        n = 0; seen = 1'b0;
        while (!out_valid[1] && n < 32) begin
            seen = seen | in_ready[1];
            tick();
            n++;
        end
        chk("t2_latency", 32'(n), 32'd3);
        for (int k = 0; k < 4; k++) begin
            seen = seen | in_ready[1];
            recv(1, 8'(15 - k), (k == 3), $sformatf("t2_b%0d", k));
        end
        seen = seen | in_ready[1];
        chk("t2_clr_done", 32'(frame_done[1]), 32'd1);
        chk("t2_ready_low", 32'(seen), 32'd0);
        tick();
        chk("t2_ready_back", 32'(in_ready[1]), 32'd1);

        // Backpressure: hold out_ready low for 5 cycles in OUT.
        out_ready[0] = 1'b0;
        send(0, 8'd3); send(0, 8'd9); send(0, 8'd1); send(0, 8'd7);
        n = 0;
        while (!out_valid[0] && n < 32) begin
            tick();
            n++;
        end
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (out_valid[0] !== 1'b1 || out_data[0] !== 8'd9 || out_last[0] !== 1'b0) stable = 1'b0;
            tick();
        end
        chk("t3_bp_stable", 32'(stable), 32'd1);
        chk("t3_bp_data",   32'(out_data[0]), 32'd9);
        out_ready[0] = 1'b1;
        recv(0, 8'd9, 1'b0, "t3_b0");
        recv(0, 8'd7, 1'b0, "t3_b1");
        recv(0, 8'd3, 1'b0, "t3_b2");
        recv(0, 8'd1, 1'b1, "t3_b3");
        tick();

        // Reset after 2 of 4 words abandons the frame and clears the sorter.
        send(0, 8'd8); send(0, 8'd6);
        rst = 1'b1; #1;
        chk("t4_rst_ready", 32'(in_ready[0]),   32'd0);
        chk("t4_rst_sclr",  32'(sorter_clr[0]), 32'd1);
        tick();
        rst = 1'b0; #1;
        chk("t4_idle_ready", 32'(in_ready[0]),  32'd1);
        chk("t4_idle_min",   32'(frame_min[0]), 32'(MIN_IDLE));
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            seen = seen | out_valid[0];
            tick();
        end
        chk("t4_no_out", 32'(seen), 32'd0);
        send(0, 8'd5); send(0, 8'd5); send(0, 8'd5); send(0, 8'd5);
        recv(0, 8'd5, 1'b0, "t4_b0");
        chk("t4_min_out", 32'(frame_min[0]), 32'(MIN_T4));
        recv(0, 8'd5, 1'b0, "t4_b1");
        recv(0, 8'd5, 1'b0, "t4_b2");
        recv(0, 8'd5, 1'b1, "t4_b3");
        tick();

        // Short frame: unfilled slots come out as zero.
        send(2, 8'd4); send(2, 8'd2);
        recv(2, 8'd4, 1'b0, "t5_b0");
        recv(2, 8'd2, 1'b0, "t5_b1");
        recv(2, 8'd0, 1'b0, "t5_b2");
        recv(2, 8'd0, 1'b1, "t5_b3");
        chk("t5_clr_done", 32'(frame_done[2]), 32'd1);
        tick();
        chk("t5_idle_ready", 32'(in_ready[2]), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sort4_frame_ctrl.md
# sort4_frame_ctrl

Frame sequencer for the 4-entry sequence sorter datapath. Accepts a stream of words over a valid/ready handshake and forwards exactly FRAME_LEN of them into the sorter. It waits out the sorter latency, then serialises the four sorted results (largest first) over an output handshake. Finally it clears the sorter for the next frame. Sits between the upstream data source and the sorter; the sorter itself stays a passive datapath.

## Interface
- DATA_WIDTH, 8, element width in bits
- FRAME_LEN, 16, elements per frame; legal range 1..65535
- SORT_LAT, 1, sorter cycles from last enabled input to settled sorter_q; legal range 1..15
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  upstream word valid
- in_ready  out  1  controller can accept a word
- in_data  in  DATA_WIDTH  upstream word
- sorter_en  out  1  sorter shift/insert enable
- sorter_din  out  DATA_WIDTH  word to sorter, equals in_data
- sorter_clr  out  1  sorter clear
- sorter_q  in  4*DATA_WIDTH  sorted sorter contents; slot 0 (LSBs) largest
- out_valid  out  1  sorted word valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_WIDTH  sorted word
- out_last  out  1  marks 4th sorted word
- frame_done  out  1  one-cycle pulse at frame end
- frame_min  out  DATA_WIDTH  smallest word of the frame (see Configuration)

## Operation
- States: IDLE, LOAD, DRAIN, OUT, CLR.
- Accept occurs when in_valid & in_ready. sorter_en = accept, combinational; sorter_din = in_data.
- in_ready = 1 in IDLE and LOAD only.
- IDLE: on accept, set cnt = 1. Go to LOAD, or to DRAIN if FRAME_LEN == 1.
- LOAD: cnt increments on each accept. The accept that makes cnt == FRAME_LEN moves to DRAIN with lat = 0. No accept means hold.
- DRAIN: lat increments each cycle. Move to OUT after exactly SORT_LAT DRAIN cycles. Set idx = 0.
- OUT: out_valid = 1; out_data = sorter_q slot idx; out_last = (idx == 3). On out_valid & out_ready, idx increments. Handshake with idx == 3 moves to CLR. out_data and out_last stay stable while out_ready is low.
- CLR: one cycle. sorter_clr = 1, frame_done = 1, cnt/idx/lat zeroed, next state IDLE. No accept in CLR.
- FRAME_LEN < 4: unfilled sorter slots hold the clear value 0. They are still emitted as output words.
- Reset values: state IDLE, cnt/lat/idx 0, in_ready 0 during rst, out_valid 0, out_last 0, sorter_en 0, frame_done 0. sorter_clr = 1 while rst is high.
- Reset mid-frame: frame is abandoned and no partial output is produced. Controller is in IDLE on the first cycle after rst falls, with a cleared sorter.

## Timing
- Last input accepted at cycle T: DRAIN occupies T+1..T+SORT_LAT, and out_valid first rises at T+SORT_LAT+1.
- With out_ready held at 1: four output beats in consecutive cycles, CLR on the next cycle, in_ready high the cycle after.
- Minimum frame period = FRAME_LEN + SORT_LAT + 4 + 1 cycles.
- Counter widths: cnt is clog2(FRAME_LEN+1) bits, lat is 4 bits, idx is 2 bits. No wrap occurs inside legal ranges.

## Configuration
- SORT4_CTRL_MIN_EN defined:
  - frame_min register updates to min(frame_min, in_data) on each accept.
  - It is set to all-ones in reset and in CLR.
  - It is valid and stable from DRAIN through OUT.
- SORT4_CTRL_MIN_EN undefined: frame_min is tied to 0 and there is no comparator or register.

## Structure
- Package sort4_pkg: state enum, the sorter slot count constant (4), and a slot-select function on the packed sorter_q.
- Sub-module sort4_beat_counter: parameterised up-counter with clear, enable and terminal flag. It is instantiated for cnt and lat.

## Test plan
- FRAME_LEN=4, SORT_LAT=1: feed 3,9,1,7 back-to-back with out_ready=1 -> out 9,7,3,1, out_last on 1. out_valid first rises 2 cycles after the accept of 7. frame_done pulses once.
- FRAME_LEN=16: feed 0..15 with in_valid toggling every other cycle -> out 15,14,13,12. in_ready is low from DRAIN through CLR.
- Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_data=9 stable and no idx advance. Words then resume in order.
- rst high for 1 cycle after 2 of 4 inputs -> no out_valid. The next 4 inputs 5,5,5,5 give out 5,5,5,5.
- FRAME_LEN=2, feed 4,2 -> out 4,2,0,0.
- SORT4_CTRL_MIN_EN defined, feed 3,9,1,7 -> frame_min = 1 during OUT and all-ones after CLR. Macro undefined -> frame_min = 0 throughout.
